// File: rtl/phy_pkg.sv
// rtl/phy_pkg.sv - shared PHY receive constants and FSM encoding
package phy_pkg;

  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] COMMA_DEFAULT = 8'hBC;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } rx_state_t;

endpackage

// File: rtl/serial_paralelo_shift.sv
// rtl/serial_paralelo_shift.sv - serial shift register with byte phase counter
module serial_paralelo_shift
  import phy_pkg::*;
(
  input  logic              clk_32f,
  input  logic              reset,
  input  logic              in_serial,
  input  logic              align,
  output logic [BYTE_W-1:0] cand,
  output logic              byte_done
);

  // Only the low seven bits of the byte register ever reach cand, so the
  // oldest bit is not kept.
  logic [BYTE_W-2:0] sr;
  logic [2:0]        bitcnt;

  assign cand      = {sr, in_serial};
  assign byte_done = (bitcnt == 3'd7);

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      sr     <= '0;
      bitcnt <= 3'd0;
    end else begin
      sr <= cand[BYTE_W-2:0];
      if (align) begin
        bitcnt <= 3'd0;
      end else begin
        bitcnt <= bitcnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/serial_paralelo_8.sv
// rtl/serial_paralelo_8.sv - comma-aligned serial to byte deserializer
module serial_paralelo_8
  import phy_pkg::*;
#(
  parameter logic [BYTE_W-1:0] COMMA      = COMMA_DEFAULT,
  parameter int                SYNC_COUNT = 4
) (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic              in_serial,
  output logic [BYTE_W-1:0] out_data8,
  output logic              valid8,
  output logic              active
);

  localparam logic [3:0] SYNC_TARGET = 4'(SYNC_COUNT);

  rx_state_t         state;
  logic [3:0]        ccnt;
  logic [3:0]        ccnt_next;
  logic [BYTE_W-1:0] cand;
  logic              byte_done;
  logic              cand_is_comma;
  logic              align;

  assign cand_is_comma = (cand == COMMA);
  assign ccnt_next     = ccnt + 4'd1;

  // Any comma seen while searching defines the new byte phase.
  assign align = (state == SEARCH) && cand_is_comma;

  serial_paralelo_shift u_shift (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .in_serial (in_serial),
    .align     (align),
    .cand      (cand),
    .byte_done (byte_done)
  );

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state     <= SEARCH;
      ccnt      <= 4'd0;
      out_data8 <= '0;
      valid8    <= 1'b0;
      active    <= 1'b0;
    end else begin
      case (state)
        SEARCH: begin
          if (cand_is_comma) begin
            ccnt <= 4'd1;
            if (SYNC_COUNT == 1) begin
              state  <= ACTIVE;
              active <= 1'b1;
            end else begin
              state <= SYNC;
            end
          end
        end

        SYNC: begin
          if (byte_done) begin
            if (cand_is_comma) begin
              ccnt <= ccnt_next;
              if (ccnt_next == SYNC_TARGET) begin
                state  <= ACTIVE;
                active <= 1'b1;
              end
            end else begin
              ccnt  <= 4'd0;
              state <= SEARCH;
            end
          end
        end

        ACTIVE: begin
          // Lock is sticky; only reset leaves this state.
          if (byte_done) begin
            out_data8 <= cand;
            valid8    <= !cand_is_comma;
          end
        end

        default: begin
          state  <= SEARCH;
          ccnt   <= 4'd0;
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_paralelo_8.md
# serial_paralelo_8

Upstream neighbour of the 8-to-32 width converter in the PHY receive path. It deserializes a 1-bit serial stream into bytes on a single fast clock. Byte alignment is found by detecting the comma symbol 0xBC, and lock is declared after a run of aligned commas. Once locked, it presents one byte plus a valid flag every 8 clocks, and that output feeds the 8-to-32 stage's `in_data8`/`in8` inputs.

## Interface
- `COMMA`, 8'hBC, alignment/idle symbol
- `SYNC_COUNT`, 4, consecutive aligned commas required to lock (range 1–15)

- `clk_32f`  in  1  serial bit clock (8× byte rate); all state changes on the rising edge
- `reset`  in  1  asynchronous, active-high
- `in_serial`  in  1  serial data, MSB first, sampled on every rising edge of `clk_32f`
- `out_data8`  out  8  last completed byte; held for 8 clocks
- `valid8`  out  1  high while `out_data8` holds a non-comma byte received in ACTIVE
- `active`  out  1  high while locked (state ACTIVE)

## Operation
- Shift register `sr[7:0]` loads `{sr[6:0], in_serial}` every edge.
- `cand` = `{sr[6:0], in_serial}` is the byte completed at the current edge.
- Bit counter `bitcnt` (3 bits, 0..7) and comma counter `ccnt` (4 bits).
- FSM states:
  - SEARCH: checks `cand` on every edge.
    - `cand == COMMA`: `bitcnt <= 0`, `ccnt <= 1`.
      - If `SYNC_COUNT == 1`, go to ACTIVE.
      - Otherwise go to SYNC.
    - Any other value: stay in SEARCH.
  - SYNC: `bitcnt` increments and wraps 7→0. `cand` is checked only on edges where `bitcnt == 7`.
    - `cand == COMMA`: `ccnt++`. When the new `ccnt == SYNC_COUNT`, go to ACTIVE.
    - Any other value: `ccnt <= 0`, return to SEARCH.
  - ACTIVE: `bitcnt` keeps counting. On edges where `bitcnt == 7`:
    - `out_data8 <= cand`
    - `valid8 <= (cand != COMMA)`
  - Lock is never dropped once ACTIVE; only `reset` leaves ACTIVE.
- `active` is a registered output, equal to "state is ACTIVE". It rises on the same edge that enters ACTIVE.
- Comma patterns that straddle a byte boundary in SYNC or ACTIVE are ignored, because `cand` is only checked when `bitcnt == 7`.
- Reset values, applied asynchronously and immediately on `reset` high:
  - state = SEARCH
  - `sr`, `bitcnt`, `ccnt` = 0
  - `out_data8` = 8'h00, `valid8` = 0, `active` = 0
- Reset mid-stream (in any state) discards the partial byte. Relock after reset needs the full `SYNC_COUNT` comma sequence again.

## Timing
- Latency: the last bit (LSB) of a byte is sampled at edge E. `out_data8`/`valid8` are updated by E and stable until E+8.
- Lock timing: the first comma completes at edge E0. `active` rises at E0 + 8·(`SYNC_COUNT` − 1). With the default, that is E0+24.
- In ACTIVE, outputs change only every 8th edge.
- `valid8` is level-based, not a pulse: it stays high for 8 clocks per data byte.
- The downstream stage samples on `clk_4f` (= `clk_32f`/8). The 8-clock hold guarantees at least one stable sample per byte.
- No back-pressure: the downstream stage must accept one byte every 8 clocks.

## Structure
- Shared package `phy_pkg`: `COMMA` default (8'hBC), FSM state encoding (SEARCH=2'd0, SYNC=2'd1, ACTIVE=2'd2), `BYTE_W = 8`.
- One natural sub-module, `serial_paralelo_shift`: the 8-bit shift register plus 3-bit wrap counter, exporting `cand` and `byte_done` (`bitcnt == 7`).
- The FSM and output registers live in the top module.

## Test plan
- Clean lock: reset, then serial stream 0xBC×4, 0x0F, 0x0D, 0x03.
  - `active` rises at the end of the 4th comma.
  - `out_data8` shows 0x0F, 0x0D, 0x03, each with `valid8 = 1` for 8 clocks.
- Misaligned start: 3 garbage bits (1,0,1), then 0xBC×4, 0xA5.
  - Lock occurs anyway.
  - `out_data8` = 0xA5 with `valid8 = 1`.
- Broken sync: 0xBC, 0xBC, 0x55, 0xBC×4, 0x11.
  - `active` stays 0 through the 0x55 byte.
  - Lock occurs only after the later four commas, then 0x11 is valid.
- Idle in ACTIVE: after lock, send 0x22, 0xBC, 0x33.
  - `valid8` sequence is 1, 0, 1.
  - `out_data8` sequence is 0x22, 0xBC, 0x33.
- Reset mid-operation: assert `reset` between clock edges in the middle of byte 0x0D while ACTIVE.
  - All outputs go to 0 immediately.
  - After release, data without commas never raises `active`.
- Non-default parameter: `SYNC_COUNT = 1`.
  - A single 0xBC locks (`active` rises on the edge that completes it).
  - The next byte, 0x7E, is valid.
